// File: rtl/alu_muldiv_if.sv
// Handshake and operand bus between the EX stage and the multiply/divide unit.
// The master side (pipeline) drives the operation; the slave side (unit) answers.
interface alu_muldiv_if #(
   parameter int DATA_WIDTH    = 32,
   parameter int OPCODE_LENGTH = 3
);
   logic                     flush;
   logic                     in_valid;
   logic                     in_ready;
   logic [DATA_WIDTH-1:0]    SrcA;
   logic [DATA_WIDTH-1:0]    SrcB;
   logic [OPCODE_LENGTH-1:0] Operation;
   logic                     out_valid;
   logic                     out_ready;
   logic [DATA_WIDTH-1:0]    Result;
   logic                     busy;

   modport master (
      output flush, in_valid, SrcA, SrcB, Operation, out_ready,
      input  in_ready, out_valid, Result, busy
   );

   modport slave (
      input  flush, in_valid, SrcA, SrcB, Operation, out_ready,
      output in_ready, out_valid, Result, busy
   );
endinterface

// File: rtl/alu_muldiv.sv
// Multi-cycle RV32M execute unit: radix-2 shift-add multiply and restoring
// divide, one step per clock, with valid/ready handshakes and a pipeline flush.
// Operands are converted to magnitudes on accept and the sign is fixed up on
// the final step, so the iterative datapath is purely unsigned.
module alu_muldiv #(
   parameter int DATA_WIDTH    = 32,
   parameter int OPCODE_LENGTH = 3
) (
   input logic         clk,
   input logic         reset,
   alu_muldiv_if.slave bus
);
   localparam int W  = DATA_WIDTH;
   localparam int CW = $clog2(DATA_WIDTH + 1);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   count_q, count_d;
   logic [2*W-1:0]  acc_q, acc_d;
   logic [W-1:0]    operand_q, operand_d;
   logic [2:0]      op_q, op_d;
   logic            signA_q, signA_d;
   logic            signB_q, signB_d;
   logic [W-1:0]    result_q, result_d;

   logic [2:0]      opIn;
   logic            aSignedIn, bSignedIn, negAIn, negBIn;
   logic [W-1:0]    magA, magB;
   logic            divZeroIn, overflowIn, acceptIn;
   logic [W:0]      mulSum, divDiff;
   logic [2*W-1:0]  mulStep, divStep, stepAcc, product;
   logic [W-1:0]    quotient, remainder, finalResult;

   // Operand decode: which operands count as signed and their magnitudes.
   assign opIn       = bus.Operation[2:0];
   assign aSignedIn  = (opIn == 3'b001) || (opIn == 3'b010) || (opIn == 3'b100) || (opIn == 3'b110);
   assign bSignedIn  = (opIn == 3'b001) || (opIn == 3'b100) || (opIn == 3'b110);
   assign negAIn     = aSignedIn && bus.SrcA[W-1];
   assign negBIn     = bSignedIn && bus.SrcB[W-1];
   assign magA       = negAIn ? ({W{1'b0}} - bus.SrcA) : bus.SrcA;
   assign magB       = negBIn ? ({W{1'b0}} - bus.SrcB) : bus.SrcB;
   assign divZeroIn  = opIn[2] && (bus.SrcB == {W{1'b0}});
   assign overflowIn = opIn[2] && !opIn[0] && (bus.SrcA == {1'b1, {(W-1){1'b0}}})
                       && (bus.SrcB == {W{1'b1}});
   assign acceptIn   = bus.in_valid && !bus.flush;

   // One iteration: multiply keeps {partial product, multiplier} in acc_q,
   // divide keeps {remainder, quotient} in acc_q; operand_q holds the other value.
   assign mulSum  = {1'b0, acc_q[2*W-1:W]} + {1'b0, operand_q};
   assign mulStep = acc_q[0] ? {mulSum, acc_q[W-1:1]} : {1'b0, acc_q[2*W-1:1]};
   assign divDiff = acc_q[2*W-1:W-1] - {1'b0, operand_q};
   assign divStep = divDiff[W] ? {acc_q[2*W-2:0], 1'b0}
                               : {divDiff[W-1:0], acc_q[W-2:0], 1'b1};
   assign stepAcc = op_q[2] ? divStep : mulStep;

   // Sign correction applied to the value produced by the last iteration.
   assign product   = (signA_q ^ signB_q) ? ({(2*W){1'b0}} - stepAcc) : stepAcc;
   assign quotient  = (signA_q ^ signB_q) ? ({W{1'b0}} - stepAcc[W-1:0]) : stepAcc[W-1:0];
   assign remainder = signA_q ? ({W{1'b0}} - stepAcc[2*W-1:W]) : stepAcc[2*W-1:W];

   // Pick the half or field of the finished computation that the op returns.
   always_comb begin
      finalResult = product[W-1:0];
      unique case (op_q)
         3'b000:                 finalResult = product[W-1:0];
         3'b001, 3'b010, 3'b011: finalResult = product[2*W-1:W];
         3'b100, 3'b101:         finalResult = quotient;
         default:                finalResult = remainder;
      endcase
   end

   // Next-state logic: accept in IDLE, iterate in CALC, hold in DONE; flush overrides all.
   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      acc_d     = acc_q;
      operand_d = operand_q;
      op_d      = op_q;
      signA_d   = signA_q;
      signB_d   = signB_q;
      result_d  = result_q;
      unique case (state_q)
         IDLE: begin
            if (acceptIn) begin
               op_d    = opIn;
               signA_d = negAIn;
               signB_d = negBIn;
               if (divZeroIn) begin
                  result_d = opIn[1] ? bus.SrcA : {W{1'b1}};
                  state_d  = DONE;
               end else if (overflowIn) begin
                  result_d = opIn[1] ? {W{1'b0}} : bus.SrcA;
                  state_d  = DONE;
               end else begin
                  acc_d     = {{W{1'b0}}, (opIn[2] ? magA : magB)};
                  operand_d = opIn[2] ? magB : magA;
                  count_d   = CW'(W);
                  state_d   = CALC;
               end
            end
         end
         CALC: begin
            acc_d   = stepAcc;
            count_d = count_q - CW'(1);
            if (count_q == CW'(1)) begin
               result_d = finalResult;
               state_d  = DONE;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (bus.flush) begin
         state_d = IDLE;
         count_d = '0;
      end
   end

   // State and datapath registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         count_q   <= '0;
         acc_q     <= '0;
         operand_q <= '0;
         op_q      <= '0;
         signA_q   <= 1'b0;
         signB_q   <= 1'b0;
         result_q  <= '0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         acc_q     <= acc_d;
         operand_q <= operand_d;
         op_q      <= op_d;
         signA_q   <= signA_d;
         signB_q   <= signB_d;
         result_q  <= result_d;
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.busy      = (state_q != IDLE);
   assign bus.Result    = result_q;
endmodule

// File: tb/tb_alu_muldiv.sv
// Directed bench for alu_muldiv: a vector table of RV32M operations with
// hand-computed results and latencies, plus sequences for output stall,
// flush mid-calculation and asynchronous reset mid-calculation.
module tb_alu_muldiv;
   localparam int W = 32;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   alu_muldiv_if #(.DATA_WIDTH(W), .OPCODE_LENGTH(3)) bus ();

   alu_muldiv #(.DATA_WIDTH(W), .OPCODE_LENGTH(3)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   // Free-running 100 MHz clock.
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] expected;
      int          latency;
   } vec_t;

   vec_t vecs[16];

   // Compare one value and log any disagreement.
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   // Present one operation, accept it, scramble the inputs, then wait for out_valid.
   task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a,
                                input logic [31:0] b, output int latency);
      bus.Operation = op;
      bus.SrcA      = a;
      bus.SrcB      = b;
      bus.in_valid  = 1'b1;
      stepCycle();
      bus.in_valid  = 1'b0;
      bus.SrcA      = $urandom;
      bus.SrcB      = $urandom;
      bus.Operation = 3'($urandom);
      latency = 1;
      while (!bus.out_valid && latency < 100) begin
         stepCycle();
         latency++;
      end
   endtask

   // Full transaction from the table: accept, latency, result, handshake.
   task automatic runVector(input vec_t v);
      int lat;
      checkOutput({v.name, " in_ready before"}, 32'(bus.in_ready), 32'd1);
      applyStimulus(v.op, v.a, v.b, lat);
      checkOutput({v.name, " latency"}, 32'(lat), 32'(v.latency));
      checkOutput({v.name, " result"}, bus.Result, v.expected);
      bus.out_ready = 1'b1;
      stepCycle();
      bus.out_ready = 1'b0;
      checkOutput({v.name, " out_valid after"}, 32'(bus.out_valid), 32'd0);
      checkOutput({v.name, " in_ready after"}, 32'(bus.in_ready), 32'd1);
   endtask

   // Guard against a hung DUT.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int lat;
      int seen;

      vecs[0]  = '{"MUL 7*-3",        3'b000, 32'h7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33};
      vecs[1]  = '{"MULH 7*-3",       3'b001, 32'h7,        32'hFFFFFFFD, 32'hFFFFFFFF, 33};
      vecs[2]  = '{"MULHU 7*-3",      3'b011, 32'h7,        32'hFFFFFFFD, 32'h00000006, 33};
      vecs[3]  = '{"MULHSU min*max",  3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33};
      vecs[4]  = '{"MULH min*min",    3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33};
      vecs[5]  = '{"DIV -7/2",        3'b100, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFD, 33};
      vecs[6]  = '{"REM -7%2",        3'b110, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 33};
      vecs[7]  = '{"DIVU big/3",      3'b101, 32'hFFFFFFFE, 32'h3,        32'h55555554, 33};
      vecs[8]  = '{"REMU 100%7",      3'b111, 32'd100,      32'd7,        32'h00000002, 33};
      vecs[9]  = '{"DIV 5/0",         3'b100, 32'd5,        32'h0,        32'hFFFFFFFF, 1};
      vecs[10] = '{"REM 5%0",         3'b110, 32'd5,        32'h0,        32'h00000005, 1};
      vecs[11] = '{"DIV ovf",         3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
      vecs[12] = '{"REM ovf",         3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1};
      vecs[13] = '{"DIVU 5/0",        3'b101, 32'd5,        32'h0,        32'hFFFFFFFF, 1};
      vecs[14] = '{"REMU 9%0",        3'b111, 32'd9,        32'h0,        32'h00000009, 1};
      vecs[15] = '{"MULHSU -1*2",     3'b010, 32'hFFFFFFFF, 32'h2,        32'hFFFFFFFF, 33};

      reset         = 1'b0;
      bus.flush     = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.SrcA      = '0;
      bus.SrcB      = '0;
      bus.Operation = '0;
      stepCycle();
      stepCycle();
      checkOutput("reset in_ready", 32'(bus.in_ready), 32'd1);
      checkOutput("reset out_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("reset busy", 32'(bus.busy), 32'd0);
      checkOutput("reset Result", bus.Result, 32'h0);
      reset = 1'b1;
      stepCycle();

      for (int i = 0; i < 16; i++) begin
         runVector(vecs[i]);
      end

      // Stall in DONE: result held, new requests ignored.
      applyStimulus(3'b000, 32'h7, 32'hFFFFFFFD, lat);
      checkOutput("hold latency", 32'(lat), 32'd33);
      for (int i = 0; i < 10; i++) begin
         if (i == 3) begin
            bus.Operation = 3'b000;
            bus.SrcA      = 32'd1;
            bus.SrcB      = 32'd1;
            bus.in_valid  = 1'b1;
         end
         checkOutput("hold Result", bus.Result, 32'hFFFFFFEB);
         checkOutput("hold out_valid", 32'(bus.out_valid), 32'd1);
         checkOutput("hold in_ready", 32'(bus.in_ready), 32'd0);
         stepCycle();
      end
      bus.in_valid  = 1'b0;
      checkOutput("hold busy", 32'(bus.busy), 32'd1);
      bus.out_ready = 1'b1;
      stepCycle();
      bus.out_ready = 1'b0;
      checkOutput("hold in_ready after", 32'(bus.in_ready), 32'd1);
      checkOutput("hold out_valid after", 32'(bus.out_valid), 32'd0);
      checkOutput("hold busy after", 32'(bus.busy), 32'd0);

      // Flush in the twelfth CALC cycle.
      bus.Operation = 3'b000;
      bus.SrcA      = 32'd5;
      bus.SrcB      = 32'd6;
      bus.in_valid  = 1'b1;
      stepCycle();
      bus.in_valid  = 1'b0;
      for (int i = 1; i < 12; i++) stepCycle();
      checkOutput("flush busy before", 32'(bus.busy), 32'd1);
      bus.flush = 1'b1;
      stepCycle();
      bus.flush = 1'b0;
      checkOutput("flush in_ready", 32'(bus.in_ready), 32'd1);
      checkOutput("flush busy", 32'(bus.busy), 32'd0);
      checkOutput("flush Result kept", bus.Result, 32'hFFFFFFEB);
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         if (bus.out_valid) seen++;
         stepCycle();
      end
      checkOutput("flush no out_valid", 32'(seen), 32'd0);

      // Flush beats in_valid on the same edge.
      bus.Operation = 3'b000;
      bus.SrcA      = 32'd2;
      bus.SrcB      = 32'd2;
      bus.in_valid  = 1'b1;
      bus.flush     = 1'b1;
      stepCycle();
      bus.in_valid  = 1'b0;
      bus.flush     = 1'b0;
      checkOutput("flush vs in_valid busy", 32'(bus.busy), 32'd0);
      runVector('{"MUL 3*4", 3'b000, 32'd3, 32'd4, 32'h0000000C, 33});

      // Asynchronous reset in the middle of CALC.
      bus.Operation = 3'b000;
      bus.SrcA      = 32'h7;
      bus.SrcB      = 32'hFFFFFFFD;
      bus.in_valid  = 1'b1;
      stepCycle();
      bus.in_valid  = 1'b0;
      for (int i = 0; i < 10; i++) stepCycle();
      reset = 1'b0;
      #1;
      checkOutput("async reset in_ready", 32'(bus.in_ready), 32'd1);
      checkOutput("async reset out_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("async reset busy", 32'(bus.busy), 32'd0);
      checkOutput("async reset Result", bus.Result, 32'h0);
      stepCycle();
      stepCycle();
      reset = 1'b1;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         if (bus.out_valid) seen++;
         stepCycle();
      end
      checkOutput("reset no out_valid", 32'(seen), 32'd0);
      runVector(vecs[8]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/alu_muldiv.md
Name: alu_muldiv

Overview:
- Multi-cycle RV32M execute unit, parametrised successor to the single-cycle base ALU.
- Implements MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU with a radix-2 iterative datapath: one shift-add or shift-subtract step per clock.
- Sits beside the base ALU in EX. It uses a valid/ready handshake so the hazard unit can stall the pipeline while the unit is busy, and a flush input to abort on a pipeline kill.

Parameters:
- DATA_WIDTH, 32, operand and result width; must be even and at least 8.
- OPCODE_LENGTH, 3, width of Operation; carries RV32M funct3.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous abort; returns the unit to IDLE.
- in_valid  input  1  operands and Operation are valid.
- in_ready  output  1  unit can accept an operation (high only in IDLE).
- SrcA  input  DATA_WIDTH  rs1 value (multiplicand / dividend).
- SrcB  input  DATA_WIDTH  rs2 value (multiplier / divisor).
- Operation  input  OPCODE_LENGTH  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- out_valid  output  1  Result is valid.
- out_ready  input  1  consumer accepts Result.
- Result  output  DATA_WIDTH  operation result.
- busy  output  1  state is CALC or DONE (stall request to the hazard unit).

Behaviour:
- Reset (reset low, asynchronous): state IDLE, in_ready 1, out_valid 0, busy 0, Result 0, iteration counter 0, internal registers 0.
- States: IDLE, CALC, DONE.
- IDLE -> CALC:
  - Taken on an edge with in_valid && in_ready.
  - Latches Operation, operand signs and operand magnitudes. Signed operand = negated when MSB is 1 and the op treats it as signed: MULH both operands, MULHSU SrcA only, DIV/REM both operands.
  - Loads the counter with DATA_WIDTH.
- CALC:
  - Multiply: 2*DATA_WIDTH-bit accumulator. Each edge adds the multiplicand when the multiplier LSB is 1, then shifts right by 1.
  - Divide: restoring step. Shift the {remainder, quotient} pair left 1; subtract the divisor if there is no borrow and set the quotient LSB.
  - Counter decrements on each edge. The edge where the counter goes 1 -> 0 applies sign correction, loads Result and moves to DONE.
  - Sign correction: negate the product if the signs differ; negate the quotient if the operand signs differ; the remainder takes the dividend's sign.
- Latency: Result and out_valid are valid exactly DATA_WIDTH+1 cycles after the accept edge (33 for 32-bit).
- Result selection:
  - MUL: low half of the product.
  - MULH, MULHSU, MULHU: high half.
  - DIV, DIVU: quotient.
  - REM, REMU: remainder.
- Fast paths: these skip CALC and go IDLE -> DONE on the accept edge, so out_valid is high the next cycle.
  - Divide by zero: DIV/DIVU give all ones; REM/REMU give SrcA.
  - Signed overflow (SrcA = most-negative, SrcB = -1): DIV gives SrcA; REM gives 0.
  - Multiply never takes a fast path.
- DONE:
  - out_valid high; Result is held stable until out_valid && out_ready.
  - On that handshake edge: -> IDLE, out_valid 0.
  - No back-to-back accept: in_ready goes high only in the cycle after the handshake.
- flush:
  - On an edge with flush high, any state -> IDLE, out_valid 0, counter 0; Result keeps its last value.
  - flush wins over in_valid and over out_ready on the same edge; no operation is accepted on a flush edge.
- Reset asserted mid-operation: immediate return to the reset values; no partial result is ever presented.
- in_valid while busy is ignored (in_ready 0); inputs are sampled only on the accept edge, so later changes to SrcA/SrcB do not affect the result.
- Arithmetic: all internal magnitudes are unsigned DATA_WIDTH bits; the product register is 2*DATA_WIDTH bits. The signed-overflow negation wraps mod 2^DATA_WIDTH (spec-compliant).

Test Plan:
- MUL 7 x -3 (0xFFFFFFFD): accept, then out_valid in exactly the 33rd cycle after the accept edge with Result 0xFFFFFFEB. MULH on the same operands gives 0xFFFFFFFF; MULHU gives 0x00000006.
- MULHSU with SrcA 0x80000000, SrcB 0xFFFFFFFF -> Result 0x80000000. MULH 0x80000000 x 0x80000000 -> 0x40000000.
- DIV -7 / 2 -> 0xFFFFFFFD; REM -7 % 2 -> 0xFFFFFFFF; DIVU 0xFFFFFFFE / 3 -> 0x55555554; REMU 100 % 7 -> 2. Each takes 33-cycle latency.
- DIV 5 / 0 -> 0xFFFFFFFF and REM 5 % 0 -> 5, with out_valid one cycle after accept. DIV 0x80000000 / -1 -> 0x80000000 and REM -> 0, also one cycle after accept.
- Hold out_ready low for 10 cycles in DONE: Result and out_valid must stay stable, in_ready stays 0 and a new in_valid is ignored. After the handshake, in_ready rises the next cycle.
- Assert flush at CALC cycle 12: out_valid never rises, the unit is IDLE the next cycle, and a fresh MUL 3 x 4 completes with 12. Repeat with reset pulsed low mid-CALC: all outputs return to reset values asynchronously.
